airi5c_rf_write_ctrl: RTL
=========================

# airi5c_rf_write_ctrl

Write-port controller for the AIRI5C integer/FPU register file. Shares the file's single pipeline write port between in-order writeback and a long-latency unit (FPU/divider), keeps a 64-entry pending-destination scoreboard for those results, and sequences debug-module register writes so they never race an outstanding result. Sits between the writeback stage, the long-latency units, the debug module and `airi5c_regfile`.

## Interface
- `FIFO_DEPTH`, 2: long-latency result buffer entries; power of two, at least 2.
- `XPR_LEN`, 32: data width.
- `REG_ADDR_WIDTH`, 5: register address width.
- `clk_i`  in  1  core clock; the only clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `wb_wen_i`, `wb_wa_i`[5], `wb_wd_i`/`wb_wd2_i`[32], `wb_rd64_i`, `wb_fpu_i`  in  in-order writeback; always accepted.
- `lu_valid_i`  in  1  long-latency result valid.
- `lu_ready_o`  out  1  result accepted when valid&ready.
- `lu_wa_i`  in  5  result destination register.
- `lu_wd_i`  in  32  result data.
- `lu_fpu_i`  in  1  result targets the FPU register bank.
- `iss_valid_i`, `iss_wa_i`[5], `iss_fpu_i`  in  long-latency op issued; marks destination pending.
- `iss_block_o`  out  1  issue stage must not issue long-latency ops.
- `ra1_i`..`ra3_i`[5], `sel_fpu_rs1_i`..`sel_fpu_rs3_i`  in  decode source operands.
- `hazard_o`  out  1  a source operand is pending.
- `busy_o`  out  1  scoreboard non-empty or FIFO non-empty.
- `dm_req_i`, `dm_wara_i`[5], `dm_wd_i`[32], `dm_fpu_i`  in  debug write request; held until ack.
- `dm_ack_o`  out  1  debug write performed this cycle.
- `rf_wen_o`, `rf_wa_o`, `rf_wd_o`, `rf_wd2_o`, `rf_rd64_o`, `rf_sel_fpu_rd_o`  out  regfile pipeline write port.
- `rf_dm_wen_o`, `rf_dm_wara_o`, `rf_dm_wd_o`, `rf_dm_sel_fpu_o`  out  regfile debug write port.

## Operation
- Write priority per cycle: writeback > FIFO head > debug. At most one of `rf_wen_o`/`rf_dm_wen_o` high per cycle.
- Writeback: pass-through combinational; `rf_*` = `wb_*` when `wb_wen_i`.
- LU path: push on `lu_valid_i & lu_ready_o`; `lu_ready_o` = count < FIFO_DEPTH (no push-through-pop when full). Pop when count>0 and `!wb_wen_i`; drives `rf_wen_o`, `rf_rd64_o`=0.
- Scoreboard: 64 bits `{fpu,int}`. Set on `iss_valid_i`; clear on FIFO pop to the same `{fpu,wa}`. Same-cycle set and clear of the same bit: set wins. Integer x0 never set. Issue to an already pending bit: bit stays set (pipeline prevents via `hazard_o`).
- `hazard_o` = OR over rs1..rs3 of pending bit at `{sel_fpu_rsN_i, raN_i}`; integer x0 never hazards.
- Debug FSM: IDLE -> DRAIN on `dm_req_i`. DRAIN -> GRANT when scoreboard empty and FIFO empty. GRANT: if `!wb_wen_i`, assert `rf_dm_wen_o` and `dm_ack_o` for one cycle, -> IDLE; else hold GRANT. `iss_block_o`=1 in DRAIN and GRANT.
- Debug request withdrawn in DRAIN: return to IDLE, no write.

## Timing
- Reset: FIFO empty, scoreboard clear, FSM IDLE; `lu_ready_o`=1, all other outputs 0.
- LU result reaches regfile earliest 1 cycle after acceptance; scoreboard bit clears at that same edge, so `hazard_o` drops the next cycle, with the regfile already holding the data.
- Writeback-to-regfile: 0 cycles (combinational).
- Debug ack: earliest 2 cycles after `dm_req_i` rises with idle machine (IDLE->DRAIN->GRANT).
- Reset mid-operation discards FIFO contents and pending bits; no partial writes.

## Structure
- Shared include `airi5c_rf_ctrl.vh`: FSM state encodings (IDLE/DRAIN/GRANT), scoreboard index macro `{fpu,addr}`; widths come from existing `XPR_LEN`/`REG_ADDR_WIDTH` defines.
- Sub-module `airi5c_rf_wb_fifo`: synchronous FIFO, parameterised depth/width, entry = `{fpu, wa, wd}`, count output.

## Test plan
- `wb_wen_i`=1, `wb_wa_i`=5, `wb_wd_i`=0x1234 -> same cycle `rf_wen_o`=1, `rf_wa_o`=5, `rf_wd_o`=0x1234.
- Issue int x7; `ra1_i`=7 -> `hazard_o`=1; push result 0xAA to x7 with writeback idle -> next cycle `rf_wa_o`=7, `rf_wd_o`=0xAA; following cycle `hazard_o`=0.
- Three LU results back-to-back with `wb_wen_i` high for 4 cycles -> third gets `lu_ready_o`=0; all drained in order after writeback frees, no loss.
- Same-cycle issue of FPU f3 and FIFO pop to f3 -> f3 remains pending.
- `dm_req_i` with x9 pending -> `iss_block_o`=1, no ack until x9 retired; then `dm_ack_o` one cycle with `rf_dm_wara_o`=dm address, `rf_dm_wd_o`=dm data.
- Reset asserted with 2 FIFO entries and 3 pending bits -> `busy_o`=0, `lu_ready_o`=1, no `rf_wen_o` after release.

Source files
------------

// File: rtl/airi5c_rf_write_ctrl_pkg.sv
// Shared types and defaults for the AIRI5C register-file write-port controller.
package airi5c_rf_write_ctrl_pkg;

  localparam int unsigned XPR_LEN_DEFAULT        = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEFAULT = 5;
  localparam int unsigned FIFO_DEPTH_DEFAULT     = 2;

  typedef enum logic [1:0] {
    DM_IDLE  = 2'd0,
    DM_DRAIN = 2'd1,
    DM_GRANT = 2'd2
  } dm_state_e;

  // Integer x0 is hardwired to zero, so it can never be pending nor cause a hazard.
  function automatic logic is_int_x0(input logic fpu, input logic [31:0] addr);
    return !fpu && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/airi5c_rf_write_ctrl_if.sv
// Long-latency result channel and debug write channel into the write-port controller.
interface airi5c_rf_write_ctrl_if
  import airi5c_rf_write_ctrl_pkg::*;
#(
  parameter int unsigned XPR_LEN        = XPR_LEN_DEFAULT,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
);

  logic                      lu_valid;
  logic                      lu_ready;
  logic [REG_ADDR_WIDTH-1:0] lu_wa;
  logic [XPR_LEN-1:0]        lu_wd;
  logic                      lu_fpu;

  logic                      dm_req;
  logic [REG_ADDR_WIDTH-1:0] dm_wara;
  logic [XPR_LEN-1:0]        dm_wd;
  logic                      dm_fpu;
  logic                      dm_ack;

  modport master (
    output lu_valid, lu_wa, lu_wd, lu_fpu,
    output dm_req, dm_wara, dm_wd, dm_fpu,
    input  lu_ready, dm_ack
  );

  modport slave (
    input  lu_valid, lu_wa, lu_wd, lu_fpu,
    input  dm_req, dm_wara, dm_wd, dm_fpu,
    output lu_ready, dm_ack
  );

endinterface

// File: rtl/airi5c_rf_wb_fifo.sv
// Small synchronous FIFO buffering long-latency results until the write port is free.
module airi5c_rf_wb_fifo
  import airi5c_rf_write_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = 38
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses writes even if the head drains in the same cycle.
  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/airi5c_rf_write_ctrl.sv
// Arbitrates the register file's single pipeline write port between writeback and
// long-latency results, tracks pending destinations, and sequences debug writes.
module airi5c_rf_write_ctrl
  import airi5c_rf_write_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
  parameter int unsigned XPR_LEN        = XPR_LEN_DEFAULT,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  airi5c_rf_write_ctrl_if.slave     lu_dm,

  input  logic                      wb_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_wa_i,
  input  logic [XPR_LEN-1:0]        wb_wd_i,
  input  logic [XPR_LEN-1:0]        wb_wd2_i,
  input  logic                      wb_rd64_i,
  input  logic                      wb_fpu_i,

  input  logic                      iss_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] iss_wa_i,
  input  logic                      iss_fpu_i,
  output logic                      iss_block_o,

  input  logic [REG_ADDR_WIDTH-1:0] ra1_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra2_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra3_i,
  input  logic                      sel_fpu_rs1_i,
  input  logic                      sel_fpu_rs2_i,
  input  logic                      sel_fpu_rs3_i,
  output logic                      hazard_o,
  output logic                      busy_o,

  output logic                      rf_wen_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_wa_o,
  output logic [XPR_LEN-1:0]        rf_wd_o,
  output logic [XPR_LEN-1:0]        rf_wd2_o,
  output logic                      rf_rd64_o,
  output logic                      rf_sel_fpu_rd_o,

  output logic                      rf_dm_wen_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_dm_wara_o,
  output logic [XPR_LEN-1:0]        rf_dm_wd_o,
  output logic                      rf_dm_sel_fpu_o
);

  localparam int unsigned ENTRY_W = 1 + REG_ADDR_WIDTH + XPR_LEN;
  localparam int unsigned SB_W    = 2 ** (REG_ADDR_WIDTH + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0]        fifo_din;
  logic [ENTRY_W-1:0]        fifo_dout;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      head_fpu;
  logic [REG_ADDR_WIDTH-1:0] head_wa;
  logic [XPR_LEN-1:0]        head_wd;
  logic [REG_ADDR_WIDTH:0]   head_idx;
  logic [REG_ADDR_WIDTH:0]   iss_idx;

  logic [SB_W-1:0]           sb_q, sb_d;
  dm_state_e                 state_q, state_d;
  logic                      dm_wen;

  assign fifo_din  = {lu_dm.lu_fpu, lu_dm.lu_wa, lu_dm.lu_wd};
  assign fifo_push = lu_dm.lu_valid && lu_dm.lu_ready;
  assign fifo_pop  = !fifo_empty && !wb_wen_i;
  assign {head_fpu, head_wa, head_wd} = fifo_dout;
  assign head_idx  = {head_fpu, head_wa};
  assign iss_idx   = {iss_fpu_i, iss_wa_i};

  assign lu_dm.lu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

  airi5c_rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (fifo_din),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rf_wen_o        = 1'b0;
    rf_wa_o         = '0;
    rf_wd_o         = '0;
    rf_wd2_o        = '0;
    rf_rd64_o       = 1'b0;
    rf_sel_fpu_rd_o = 1'b0;
    if (wb_wen_i) begin
      rf_wen_o        = 1'b1;
      rf_wa_o         = wb_wa_i;
      rf_wd_o         = wb_wd_i;
      rf_wd2_o        = wb_wd2_i;
      rf_rd64_o       = wb_rd64_i;
      rf_sel_fpu_rd_o = wb_fpu_i;
    end else if (fifo_pop) begin
      rf_wen_o        = 1'b1;
      rf_wa_o         = head_wa;
      rf_wd_o         = head_wd;
      rf_sel_fpu_rd_o = head_fpu;
    end
  end

  // The set is applied after the clear so a re-issue in the retiring cycle stays pending.
  always_comb begin
    sb_d = sb_q;
    if (fifo_pop) begin
      sb_d[head_idx] = 1'b0;
    end
    if (iss_valid_i && !is_int_x0(iss_fpu_i, 32'(iss_wa_i))) begin
      sb_d[iss_idx] = 1'b1;
    end
  end

  function automatic logic src_pending(input logic                      fpu,
                                       input logic [REG_ADDR_WIDTH-1:0] ra,
                                       input logic [SB_W-1:0]           sb);
    return !is_int_x0(fpu, 32'(ra)) && sb[{fpu, ra}];
  endfunction

  assign hazard_o = src_pending(sel_fpu_rs1_i, ra1_i, sb_q) ||
                    src_pending(sel_fpu_rs2_i, ra2_i, sb_q) ||
                    src_pending(sel_fpu_rs3_i, ra3_i, sb_q);
  assign busy_o   = (|sb_q) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    dm_wen  = 1'b0;
    case (state_q)
      DM_IDLE: begin
        if (lu_dm.dm_req) state_d = DM_DRAIN;
      end
      DM_DRAIN: begin
        if (!lu_dm.dm_req) begin
          state_d = DM_IDLE;
        end else if ((sb_q == '0) && fifo_empty) begin
          state_d = DM_GRANT;
        end
      end
      DM_GRANT: begin
        if (!wb_wen_i && !fifo_pop) begin
          dm_wen  = 1'b1;
          state_d = DM_IDLE;
        end
      end
      default: state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q    <= '0;
      state_q <= DM_IDLE;
    end else begin
      sb_q    <= sb_d;
      state_q <= state_d;
    end
  end

  assign iss_block_o     = (state_q != DM_IDLE);
  assign lu_dm.dm_ack    = dm_wen;
  assign rf_dm_wen_o     = dm_wen;
  assign rf_dm_wara_o    = dm_wen ? lu_dm.dm_wara : '0;
  assign rf_dm_wd_o      = dm_wen ? lu_dm.dm_wd : '0;
  assign rf_dm_sel_fpu_o = dm_wen && lu_dm.dm_fpu;

endmodule
